clk_div_sched: RTL

//  Programmable clock-enable scheduler for the interrupt subsystem. Generates
//  NUM_CH glitch-free, register-derived divided clocks (div_clk) plus
//  one-cycle tick strobes from the single pclk domain.

---
 rtl/clk_div_sched_if.sv | 27 ++
 rtl/clk_div_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/clk_div_sched_if.sv
// Configuration and clock-output bundle of the clock-enable scheduler.
// The master side owns divisor writes and run enables; the slave side owns status and divided clocks.
interface clk_div_sched_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [DIV_W-1:0]  cfg_wdata;
  logic [NUM_CH-1:0] ch_en;
  logic              rst_done;
  logic [NUM_CH-1:0] cfg_pend;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] tick;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, ch_en,
    input  rst_done, cfg_pend, div_clk, tick
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, ch_en,
    output rst_done, cfg_pend, div_clk, tick
  );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable clock-enable scheduler: NUM_CH registered 50%-duty divided clocks with tick strobes,
// a start-up delay after reset release, and divisor changes deferred to period boundaries.
module clk_div_sched #(
  parameter int                       NUM_CH    = 4,
  parameter int                       DIV_W     = 8,
  parameter int                       START_DLY = 5,
  parameter logic [NUM_CH*DIV_W-1:0]  DEF_H     = {8'd7, 8'd3, 8'd1, 8'd0}
) (
  input  logic            pclk,
  input  logic            preset_n,
  clk_div_sched_if.slave  bus
);

  localparam int AW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DLY_W = (START_DLY > 1) ? $clog2(START_DLY) : 1;

  typedef enum logic {G_WAIT, G_ACTIVE} g_state_t;
  typedef enum logic [1:0] {CH_OFF, CH_RUN, CH_STOP} ch_state_t;

  g_state_t           g_state, g_next;
  logic [DLY_W-1:0]   dly_cnt, dly_next;
  logic               active;
  logic               addr_ok;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      g_state <= G_WAIT;
      dly_cnt <= '0;
    end else begin
      g_state <= g_next;
      dly_cnt <= dly_next;
    end
  end

  // ACTIVE is entered on the START_DLY-th edge after release and held until reset.
  always_comb begin
    g_next   = g_state;
    dly_next = dly_cnt;
    case (g_state)
      G_WAIT: begin
        if (dly_cnt == DLY_W'(START_DLY - 1)) g_next = G_ACTIVE;
        else                                 dly_next = dly_cnt + 1'b1;
      end
      default: g_next = G_ACTIVE;
    endcase
  end

  assign active       = (g_state == G_ACTIVE);
  assign bus.rst_done = active;
  assign addr_ok      = (32'(bus.cfg_addr) < NUM_CH);

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_t        state_q, state_d;
      logic [DIV_W-1:0] cnt_q, cnt_d;
      logic [DIV_W-1:0] h_q, h_d;
      logic [DIV_W-1:0] ph_q, ph_d;
      logic             div_q, div_d;
      logic             pend_q, pend_d;
      logic             tick_q, tick_d;
      logic             wr_hit, at_top, boundary;

      assign wr_hit = bus.cfg_we && addr_ok && (bus.cfg_addr == AW'(i));
      assign at_top = (cnt_q == h_q);

      always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
          state_q <= CH_OFF;
          cnt_q   <= '0;
          h_q     <= DEF_H[i*DIV_W +: DIV_W];
          ph_q    <= '0;
          div_q   <= 1'b0;
          pend_q  <= 1'b0;
          tick_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          h_q     <= h_d;
          ph_q    <= ph_d;
          div_q   <= div_d;
          pend_q  <= pend_d;
          tick_q  <= tick_d;
        end
      end

      // A low-phase stop exits at once; a high-phase stop keeps counting until the falling toggle.
      always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        h_d      = h_q;
        ph_d     = ph_q;
        div_d    = div_q;
        pend_d   = pend_q;
        tick_d   = 1'b0;
        boundary = 1'b0;
        case (state_q)
          CH_OFF: begin
            if (active && bus.ch_en[i]) begin
              state_d = CH_RUN;
              cnt_d   = '0;
              div_d   = 1'b0;
            end
          end
          CH_RUN, CH_STOP: begin
            if (state_q == CH_RUN && !bus.ch_en[i] && !div_q) begin
              state_d = CH_OFF;
              cnt_d   = '0;
            end else begin
              if (at_top) begin
                cnt_d    = '0;
                div_d    = ~div_q;
                tick_d   = ~div_q;
                boundary = div_q;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
              if (bus.ch_en[i]) state_d = CH_RUN;
              else              state_d = boundary ? CH_OFF : CH_STOP;
            end
          end
          default: state_d = CH_OFF;
        endcase

        // The pending value lands on the falling toggle (or on stopping); a same-edge write re-arms it.
        if (pend_q && (boundary || state_d == CH_OFF)) begin
          h_d    = ph_q;
          pend_d = 1'b0;
        end
        if (wr_hit) begin
          if (state_q == CH_OFF) begin
            h_d = bus.cfg_wdata;
          end else begin
            ph_d   = bus.cfg_wdata;
            pend_d = 1'b1;
          end
        end
      end

      assign bus.div_clk[i]  = div_q;
      assign bus.tick[i]     = tick_q;
      assign bus.cfg_pend[i] = pend_q;
    end
  endgenerate

endmodule
